// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch unit. Owns the program counter, drives the
//                combinational instruction ROM address and selects the next PC
//                (sequential, JUMP, BONE/BZERO through a 16-entry branch-target
//                LUT, or HALT).
//                Optional feature macro: INST_COUNT_EN adds InstCount, a
//                saturating count of retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int AW        = 10,
    parameter int IW        = 9,
    parameter int LUT_DEPTH = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          BranchFlag,
    input  logic          LutWe,
    input  logic [3:0]    LutAddr,
    input  logic [AW-1:0] LutData,
    input  logic [IW-1:0] InstOut,
    output logic [AW-1:0] InstAddress,
    output logic          Running,
`ifdef INST_COUNT_EN
    output logic          Done,
    output logic [15:0]   InstCount
`else
    output logic          Done
`endif
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    localparam logic [4:0] c_op_jump  = 5'b01101;
    localparam logic [4:0] c_op_bone  = 5'b10001;
    localparam logic [4:0] c_op_bzero = 5'b10011;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_next_pc;
    logic [AW-1:0] r_lut [LUT_DEPTH];

    logic [4:0]    w_opcode;
    logic [3:0]    w_lut_idx;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_pc_inc;
    logic          w_is_halt;

    assign w_opcode  = InstOut[IW-1 -: 5];
    assign w_lut_idx = InstOut[3:0];
    // Combinational LUT read sees the pre-edge contents, so a same-cycle
    // write to the branch's entry only affects later uses.
    assign w_target  = r_lut[w_lut_idx];
    assign w_pc_inc  = r_pc + AW'(1);
    assign w_is_halt = &InstOut;

    // State and program counter register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_st_idle;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    // Next state / next PC selection; Stall in RUN freezes everything
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            c_st_idle, c_st_halted: begin
                // Core is idle here, so Start wins over Stall
                if (Start) begin
                    w_next_state = c_st_run;
                    w_next_pc    = StartAddr;
                end
            end
            c_st_run: begin
                if (!Stall) begin
                    if (w_is_halt) begin
                        w_next_state = c_st_halted;
                    end else if (w_opcode == c_op_jump) begin
                        w_next_pc = w_target;
                    end else if (w_opcode == c_op_bone) begin
                        w_next_pc = BranchFlag ? w_target : w_pc_inc;
                    end else if (w_opcode == c_op_bzero) begin
                        w_next_pc = BranchFlag ? w_pc_inc : w_target;
                    end else begin
                        w_next_pc = w_pc_inc;
                    end
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Outputs are pure decodes of the registered state
    always_comb begin
        InstAddress = r_pc;
        Running     = (r_state == c_st_run);
        Done        = (r_state == c_st_halted);
    end

    // Branch-target LUT, writable in any state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (LutWe) begin
            r_lut[LutAddr] <= LutData;
        end
    end

`ifdef INST_COUNT_EN
    logic        w_retire;
    logic        w_start_take;
    logic [15:0] r_count;

    assign w_retire     = (r_state == c_st_run) && !Stall;
    assign w_start_take = (r_state != c_st_run) && Start;
    assign InstCount    = r_count;

    // Saturating retired-instruction counter, cleared when a program starts
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (w_start_take) begin
            r_count <= '0;
        end else if (w_retire && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Testbench for inst_fetch: directed scenarios followed by a
//                randomized program run, compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int AW = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          stall = 1'b0;
    logic          flag = 1'b0;
    logic          lut_we = 1'b0;
    logic [3:0]    lut_addr = '0;
    logic [AW-1:0] lut_data = '0;
    logic [8:0]    inst_out;
    logic [AW-1:0] inst_addr;
    logic          running;
    logic          done;
`ifdef INST_COUNT_EN
    logic [15:0]   inst_count;
`endif

    logic [8:0]    rom   [0:1023];
    logic [AW-1:0] lut_m [0:15];
    logic [AW-1:0] m_pc;
    int            m_mode;
    int            m_cnt;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    always_comb inst_out = rom[inst_addr];

    inst_fetch #(.AW(AW), .IW(9), .LUT_DEPTH(16)) dut (
        .Clk(clk), .Reset(reset_n), .Start(start), .StartAddr(start_addr),
        .Stall(stall), .BranchFlag(flag), .LutWe(lut_we), .LutAddr(lut_addr),
        .LutData(lut_data), .InstOut(inst_out), .InstAddress(inst_addr),
        .Running(running),
`ifdef INST_COUNT_EN
        .Done(done), .InstCount(inst_count)
`else
        .Done(done)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"}, 32'(inst_addr), 32'(m_pc));
        check({tag, " running"}, 32'(running), 32'(m_mode == M_RUN));
        check({tag, " done"}, 32'(done), 32'(m_mode == M_HALT));
`ifdef INST_COUNT_EN
        check({tag, " count"}, 32'(inst_count), 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_mode = M_IDLE;
        m_cnt = 0;
        for (int i = 0; i < 16; i++) lut_m[i] = '0;
    endtask

    // One clock edge of the behavioural model, from the current inputs
    task automatic model_edge();
        logic [8:0]    ins;
        logic [AW-1:0] npc;
        int            nmode;
        int            ncnt;
        ins = rom[m_pc];
        npc = m_pc;
        nmode = m_mode;
        ncnt = m_cnt;
        if (m_mode != M_RUN) begin
            if (start) begin
                npc = start_addr;
                nmode = M_RUN;
                ncnt = 0;
            end
        end else if (!stall) begin
            ncnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (ins == 9'h1FF)                      nmode = M_HALT;
            else if (ins[8:4] == 5'b01101)          npc = lut_m[ins[3:0]];
            else if (ins[8:4] == 5'b10001 && flag)  npc = lut_m[ins[3:0]];
            else if (ins[8:4] == 5'b10011 && !flag) npc = lut_m[ins[3:0]];
            else                                    npc = AW'((m_pc + 1) % 1024);
        end
        if (lut_we) lut_m[lut_addr] = lut_data;
        m_pc = npc;
        m_mode = nmode;
        m_cnt = ncnt;
    endtask

    // Inputs are changed at the falling edge; outputs are checked there too
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic quiet();
        start = 1'b0;
        stall = 1'b0;
        lut_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("reset async");
        @(negedge clk);
        check_model("reset held");
        reset_n = 1'b1;
    endtask

    function automatic logic [8:0] rand_inst();
        int r;
        r = $urandom_range(0, 99);
        if (r < 6)  return 9'h1FF;
        if (r < 26) return {5'b01101, 4'($urandom)};
        if (r < 46) return {5'b10001, 4'($urandom)};
        if (r < 66) return {5'b10011, 4'($urandom)};
        return 9'($urandom_range(0, 510));
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[64]  = 9'h1FF;
        rom[68]  = 9'h1FF;
        rom[100] = 9'b100010011;
        rom[131] = 9'b100010011;
        rom[132] = 9'b100110011;
        rom[133] = 9'b100110011;
        rom[63]  = 9'b011010000;
        rom[4]   = 9'h1FF;
        rom[167] = 9'h1FF;
        rom[0]   = 9'b011010101;
        rom[300] = 9'b011010101;
        rom[400] = 9'h1FF;

        #2;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset pc", 32'(inst_addr), 0);
        check("reset running", 32'(running), 0);
        check("reset done", 32'(done), 0);
        reset_n = 1'b1;

        // T1: async reset mid-RUN at PC=37
        start = 1'b1; start_addr = 10'd37;
        cycle("T1 start");
        quiet();
        check("T1 pc37", 32'(inst_addr), 37);
        do_reset();
        check("T1 pc after reset", 32'(inst_addr), 0);
        check("T1 running after reset", 32'(running), 0);

        // T2: sequential fetch from 65
        start = 1'b1; start_addr = 10'd65;
        cycle("T2 a");
        quiet();
        check("T2 pc65", 32'(inst_addr), 65);
        cycle("T2 b");
        check("T2 pc66", 32'(inst_addr), 66);
        cycle("T2 c");
        check("T2 pc67", 32'(inst_addr), 67);
        cycle("T2 d");
        cycle("T2 halt");
        check("T2 done", 32'(done), 1);

        // LUT loads while halted
        lut_we = 1'b1;
        lut_addr = 4'd3; lut_data = 10'd131; cycle("lut3");
        lut_addr = 4'd0; lut_data = 10'd4;   cycle("lut0");
        lut_addr = 4'd5; lut_data = 10'd300; cycle("lut5");
        quiet();

        // T3: BONE / BZERO both ways
        start = 1'b1; start_addr = 10'd100;
        cycle("T3 start");
        quiet();
        flag = 1'b1; cycle("T3 bone taken");
        check("T3 bone taken pc", 32'(inst_addr), 131);
        flag = 1'b0; cycle("T3 bone not taken");
        check("T3 bone fall pc", 32'(inst_addr), 132);
        flag = 1'b1; cycle("T3 bzero not taken");
        check("T3 bzero fall pc", 32'(inst_addr), 133);
        flag = 1'b0; cycle("T3 bzero taken");
        check("T3 bzero taken pc", 32'(inst_addr), 131);
        rom[131] = 9'h1FF;
        cycle("T3 halt");

        // T4: JUMP, first stalled
        start = 1'b1; start_addr = 10'd63;
        cycle("T4 start");
        quiet();
        stall = 1'b1; cycle("T4 stalled");
        check("T4 stall pc", 32'(inst_addr), 63);
        stall = 1'b0; cycle("T4 jump");
        check("T4 jump pc", 32'(inst_addr), 4);
        cycle("T4 halt");

        // T5: HALT, stall over HALT, restart with Start+Stall
        start = 1'b1; start_addr = 10'd64;
        cycle("T5 start");
        quiet();
        stall = 1'b1; cycle("T5 stall over halt");
        check("T5 still running", 32'(running), 1);
        stall = 1'b0; cycle("T5 halt");
        check("T5 done", 32'(done), 1);
        check("T5 halt pc", 32'(inst_addr), 64);
        cycle("T5 hold");
        start = 1'b1; stall = 1'b1; start_addr = 10'd166;
        cycle("T5 restart");
        quiet();
        check("T5 restart pc", 32'(inst_addr), 166);
        check("T5 restart running", 32'(running), 1);
`ifdef INST_COUNT_EN
        check("T5 count cleared", 32'(inst_count), 0);
`endif
        start = 1'b1; start_addr = 10'd5;
        cycle("T5 start ignored in run");
        quiet();
        check("T5 ignored start pc", 32'(inst_addr), 167);
        cycle("T5 halt2");

        // T6: PC wrap and LUT write/read collision
        start = 1'b1; start_addr = 10'd1023;
        cycle("T6 start");
        quiet();
        cycle("T6 wrap");
        check("T6 wrap pc", 32'(inst_addr), 0);
        lut_we = 1'b1; lut_addr = 4'd5; lut_data = 10'd400;
        cycle("T6 jump old target");
        quiet();
        check("T6 old target", 32'(inst_addr), 300);
        cycle("T6 jump new target");
        check("T6 new target", 32'(inst_addr), 400);
        cycle("T6 halt");

        // Randomized program run
        do_reset();
        for (int i = 0; i < 1024; i++) rom[i] = rand_inst();
        for (int n = 0; n < 3000; n++) begin
            start      = ($urandom_range(0, 7) == 0);
            start_addr = AW'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            flag       = 1'($urandom);
            lut_we     = ($urandom_range(0, 5) == 0);
            lut_addr   = 4'($urandom);
            lut_data   = AW'($urandom);
            cycle("rand");
        end
        quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
